// File: rtl/blur_pkg.sv
// ---------------------------------------------------------------------------
// blur_pkg
// Shared constants, state encoding and sizing helper for the 5x5 blur
// window scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package blur_pkg;

  localparam int PX_WIDTH_DEF    = 8;
  localparam int FILTER_DIM_DEF  = 5;
  localparam int FILTER_SIZE_DEF = FILTER_DIM_DEF * FILTER_DIM_DEF;
  localparam int BLUR_CYCLES_DEF = 27;
  // Number of stored lines: the window needs FILTER_DIM-1 past lines.
  localparam int LB_LINES        = FILTER_DIM_DEF - 1;

  // Default counter widths for the nominal 640x480 frame.
  localparam int COL_W_DEF = $clog2(640);
  localparam int ROW_W_DEF = $clog2(480 + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/blur_line_buffer.sv
// ---------------------------------------------------------------------------
// blur_line_buffer
// Four rotating line memories. One synchronous write port into the line
// selected by line_sel, four combinational read ports at the same column,
// ordered oldest line first. The oldest line is the one being overwritten,
// so the read of it happens before the write in the same cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int PX_WIDTH  = PX_WIDTH_DEF,
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = cnt_width(IMG_WIDTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [1:0]                   line_sel,
  input  logic [COL_W-1:0]             col,
  input  logic [PX_WIDTH-1:0]          wr_px,
  output logic [LB_LINES*PX_WIDTH-1:0] rd_px
);

  logic [PX_WIDTH-1:0] mem [LB_LINES][IMG_WIDTH];

  // Store the incoming pixel into the current line at its column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[line_sel][col] <= wr_px;
    end
  end

  // Read port k returns the line written k+1 rows... oldest first:
  // line_sel holds row-4, line_sel+1 holds row-3, and so on.
  for (genvar k = 0; k < LB_LINES; k++) begin : g_rd
    logic [1:0] phys;
    assign phys = line_sel + 2'(k);
    assign rd_px[k*PX_WIDTH +: PX_WIDTH] = mem[phys][col];
  end

endmodule

`default_nettype wire

// File: rtl/blur_window_scheduler.sv
// ---------------------------------------------------------------------------
// blur_window_scheduler
// Raster pixel front end for the 5x5 blur unit: buffers four lines, builds
// the 25-pixel window, restarts and times the blur unit per interior pixel,
// and hands the result downstream with valid/ready.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blur_window_scheduler
  import blur_pkg::*;
#(
  parameter int PX_WIDTH    = PX_WIDTH_DEF,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int FILTER_DIM  = FILTER_DIM_DEF,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int BLUR_CYCLES = BLUR_CYCLES_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PX_WIDTH-1:0]             px_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sof,
  output logic [PX_WIDTH*FILTER_SIZE-1:0] win_px,
  output logic                            blur_clr,
  input  logic [PX_WIDTH-1:0]             blur_px,
  input  logic                            blur_done,
  output logic [PX_WIDTH-1:0]             px_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_done,
  output logic                            err
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT + 1);
  localparam int CNT_W = cnt_width(BLUR_CYCLES);
  localparam int WIN_W = PX_WIDTH * FILTER_SIZE;

  state_t                      state;
  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [1:0]                  line_sel;
  logic [CNT_W-1:0]            cnt;
  logic                        last_px;

  logic                        accept;
  logic                        overrun;
  logic                        take;
  logic                        win_ok;
  logic [COL_W-1:0]            eff_col;
  logic [ROW_W-1:0]            eff_row;
  logic [1:0]                  eff_sel;
  logic [LB_LINES*PX_WIDTH-1:0] lb_rd;
  logic [WIN_W-1:0]            win_nxt;

  // sof pins the accepted pixel to (0,0) regardless of the running counters.
  assign accept  = in_valid && in_ready;
  assign eff_col = sof ? '0 : col;
  assign eff_row = sof ? '0 : row;
  assign eff_sel = sof ? 2'd0 : line_sel;
  assign overrun = !sof && (row == ROW_W'(IMG_HEIGHT));
  assign take    = accept && !overrun;
  assign win_ok  = (eff_row >= ROW_W'(FILTER_DIM - 1)) &&
                   (eff_col >= COL_W'(FILTER_DIM - 1));

  // Completion is flagged in the handshake cycle of the last interior pixel.
  assign frame_done = (state == OUTPUT) && out_ready && last_px;

  blur_line_buffer #(
    .PX_WIDTH  (PX_WIDTH),
    .IMG_WIDTH (IMG_WIDTH),
    .COL_W     (COL_W)
  ) u_line_buffer (
    .clk      (clk),
    .we       (take),
    .line_sel (eff_sel),
    .col      (eff_col),
    .wr_px    (px_in),
    .rd_px    (lb_rd)
  );

  // Next window: every row shifts left, new column enters on the right.
  always_comb begin
    win_nxt = win_px;
    for (int r = 0; r < FILTER_DIM; r++) begin
      for (int c = 0; c < FILTER_DIM - 1; c++) begin
        win_nxt[(r*FILTER_DIM + c)*PX_WIDTH +: PX_WIDTH] =
          win_px[(r*FILTER_DIM + c + 1)*PX_WIDTH +: PX_WIDTH];
      end
    end
    for (int r = 0; r < FILTER_DIM - 1; r++) begin
      win_nxt[(r*FILTER_DIM + FILTER_DIM - 1)*PX_WIDTH +: PX_WIDTH] =
        lb_rd[r*PX_WIDTH +: PX_WIDTH];
    end
    win_nxt[(FILTER_SIZE-1)*PX_WIDTH +: PX_WIDTH] = px_in;
  end

  // Raster counters, window register and the per-pixel blur sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      line_sel  <= 2'd0;
      cnt       <= '0;
      last_px   <= 1'b0;
      win_px    <= '0;
      in_ready  <= 1'b0;
      blur_clr  <= 1'b1;
      px_out    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (take) begin
        win_px <= win_nxt;
        if (eff_col == COL_W'(IMG_WIDTH - 1)) begin
          col      <= '0;
          row      <= eff_row + ROW_W'(1);
          line_sel <= eff_sel + 2'd1;
        end else begin
          col      <= eff_col + COL_W'(1);
          row      <= eff_row;
          line_sel <= eff_sel;
        end
      end
      // Pixels past the end of the frame are dropped and flagged.
      if (accept && overrun) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          blur_clr <= 1'b1;
          if (take && win_ok) begin
            state    <= CLEAR;
            in_ready <= 1'b0;
            last_px  <= (eff_row == ROW_W'(IMG_HEIGHT - 1)) &&
                        (eff_col == COL_W'(IMG_WIDTH - 1));
          end
        end
        CLEAR: begin
          blur_clr <= 1'b0;
          cnt      <= '0;
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BLUR_CYCLES - 1)) begin
            px_out    <= blur_px;
            out_valid <= 1'b1;
            blur_clr  <= 1'b1;
            state     <= OUTPUT;
            if (!blur_done) begin
              err <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blur_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_blur_window_scheduler
// Directed bench for the blur window scheduler on an 8x6 frame with a
// behavioural blur unit that returns the window centre pixel.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_blur_window_scheduler;

  localparam int PXW = 8;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int BC  = 27;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PXW-1:0] px_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           sof = 1'b0;
  logic [PXW*25-1:0] win_px;
  logic           blur_clr;
  logic [PXW-1:0] blur_px = '0;
  logic           blur_done = 1'b0;
  logic [PXW-1:0] px_out;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           frame_done;
  logic           err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic done_ok = 1'b1;
  logic [PXW-1:0] outq[$];
  int lat_q[$];
  int fd_cnt = 0;
  int fd_at = 0;
  logic prev_ov = 1'b0;
  int bcnt = 0;

  blur_window_scheduler #(
    .PX_WIDTH    (PXW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .FILTER_DIM  (5),
    .FILTER_SIZE (25),
    .BLUR_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .px_in      (px_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sof        (sof),
    .win_px     (win_px),
    .blur_clr   (blur_clr),
    .blur_px    (blur_px),
    .blur_done  (blur_done),
    .px_out     (px_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Blur unit model: result (window centre) and done after 26 cycles.
  always @(posedge clk) begin
    if (blur_clr) begin
      bcnt      <= 0;
      blur_done <= 1'b0;
      blur_px   <= '0;
    end else begin
      bcnt <= bcnt + 1;
      if (bcnt >= 25) begin
        blur_done <= done_ok;
        blur_px   <= win_px[12*PXW +: PXW];
      end
    end
  end

  // Output monitor: handshakes, frame_done pulses, accept-to-valid latency.
  always @(negedge clk) begin
    if (out_valid && out_ready) outq.push_back(px_out);
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_at  = outq.size();
    end
    if (out_valid && !prev_ov) lat_q.push_back(cyc - acc_cyc);
    prev_ov = out_valid;
  end

  function automatic logic [PXW-1:0] pix_val(input int mode, input int idx);
    case (mode)
      0:       return 8'd100;
      1:       return 8'(idx);
      default: return 8'(2*idx + 1);
    endcase
  endfunction

  // Ramp centre value for the i-th interior output (raster order).
  function automatic logic [PXW-1:0] ramp_exp(input int i);
    return 8'((2 + i/4) * W + (2 + i%4));
  endfunction

  task automatic clear_mon();
    outq.delete();
    lat_q.delete();
    fd_cnt = 0;
    fd_at  = 0;
  endtask

  task automatic send_px(input logic [PXW-1:0] p, input logic s);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_px_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    px_in    = p;
    sof      = s;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    sof      = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_range(input int mode, input int from, input int to, input logic first_sof);
    for (int i = from; i <= to; i++) send_px(pix_val(mode, i), first_sof && (i == from));
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (outq.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_sig_ov();
    int k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_run();
    int k = 0;
    while (blur_clr && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (blur_clr !== 1'b1) begin errors++; $display("FAIL reset_blur_clr got=%0b exp=1", blur_clr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (px_out !== 8'd0) begin errors++; $display("FAIL reset_px_out got=%0d exp=0", px_out); end
    checks++; if (win_px !== '0) begin errors++; $display("FAIL reset_win_px got=%0h exp=0", win_px); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_constant();
    int bad = 0;
    clear_mon();
    send_range(0, 0, W*H-1, 1'b1);
    wait_out(8);
    repeat (5) @(negedge clk);
    checks++; if (outq.size() != 8) begin errors++; $display("FAIL const_count got=%0d exp=8", outq.size()); end
    foreach (outq[i]) if (outq[i] !== 8'd100) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL const_values wrong=%0d exp=0", bad); end
    bad = 0;
    foreach (lat_q[i]) if (lat_q[i] != 28) bad++;
    // out_valid rises on the 28th edge after the accepting edge, i.e. it is
    // present in the 29th cycle after the accept cycle.
    checks++; if (bad != 0 || lat_q.size() != 8) begin errors++; $display("FAIL const_latency wrong=%0d n=%0d exp 8 of 28", bad, lat_q.size()); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL const_frame_done_count got=%0d exp=1", fd_cnt); end
    checks++; if (fd_at != 8) begin errors++; $display("FAIL const_frame_done_pos got=%0d exp=8", fd_at); end
  endtask

  task automatic test_ramp();
    int bad = 0;
    clear_mon();
    send_range(1, 0, 36, 1'b1);
    wait_run();
    checks++; if (win_px[0 +: PXW] !== 8'd0) begin errors++; $display("FAIL ramp_slot0 got=%0d exp=0", win_px[0 +: PXW]); end
    checks++; if (win_px[12*PXW +: PXW] !== 8'd18) begin errors++; $display("FAIL ramp_slot12 got=%0d exp=18", win_px[12*PXW +: PXW]); end
    checks++; if (win_px[24*PXW +: PXW] !== 8'd36) begin errors++; $display("FAIL ramp_slot24 got=%0d exp=36", win_px[24*PXW +: PXW]); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (win_px[(r*5+c)*PXW +: PXW] !== 8'(r*W + c)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ramp_window wrong_slots=%0d exp=0", bad); end
    send_range(1, 37, W*H-1, 1'b0);
    wait_out(8);
    checks++; if (outq.size() != 8) begin errors++; $display("FAIL ramp_count got=%0d exp=8", outq.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outq[i] !== ramp_exp(i)) begin errors++; $display("FAIL ramp_out%0d got=%0d exp=%0d", i, outq[i], ramp_exp(i)); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ramp_err got=%0b exp=0", err); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_mon();
    out_ready = 1'b0;
    send_range(1, 0, 36, 1'b1);
    wait_sig_ov();
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || px_out !== 8'd18 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold unstable_cycles=%0d exp=0 (ov=%0b px=%0d rdy=%0b)", bad, out_valid, px_out, in_ready); end
    out_ready = 1'b1;
    send_range(1, 37, W*H-1, 1'b0);
    wait_out(8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (outq[i] !== ramp_exp(i)) bad++;
    checks++; if (outq.size() != 8 || bad != 0) begin errors++; $display("FAIL bp_sequence count=%0d wrong=%0d exp 8 and 0", outq.size(), bad); end
  endtask

  task automatic test_sof_restart();
    int bad = 0;
    clear_mon();
    send_range(1, 0, 28, 1'b1);        // up to (3,4)
    send_range(2, 0, 35, 1'b1);        // restart at old (3,5); new frame to (4,3)
    repeat (40) @(negedge clk);
    checks++; if (outq.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL sof_early_output count=%0d ov=%0b exp 0", outq.size(), out_valid); end
    send_range(2, 36, W*H-1, 1'b0);
    wait_out(8);
    for (int i = 0; i < 8; i++) if (outq[i] !== 8'(2*ramp_exp(i) + 1)) bad++;
    checks++; if (outq.size() != 8 || bad != 0) begin errors++; $display("FAIL sof_sequence count=%0d wrong=%0d exp 8 and 0", outq.size(), bad); end
  endtask

  task automatic test_overrun();
    clear_mon();
    send_px(8'h55, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err got=%0b exp=1", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL overrun_in_ready got=%0b exp=1", in_ready); end
    repeat (35) @(negedge clk);
    checks++; if (outq.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL overrun_output count=%0d ov=%0b exp 0", outq.size(), out_valid); end
  endtask

  task automatic test_reset_in_run();
    clear_mon();
    send_range(1, 0, 36, 1'b1);
    wait_run();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || blur_clr !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_run_async ov=%0b clr=%0b rdy=%0b exp 0 1 0", out_valid, blur_clr, in_ready);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_run_err got=%0b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_in_ready got=%0b exp=1", in_ready); end
    // Counters must be back at (0,0): a frame without sof lines up correctly.
    send_range(1, 0, W*H-1, 1'b0);
    wait_out(8);
    checks++; if (outq.size() != 8 || outq[0] !== 8'd18 || outq[7] !== 8'd29) begin
      errors++; $display("FAIL rst_run_frame count=%0d first=%0d last=%0d exp 8 18 29", outq.size(), outq[0], outq[7]);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    done_ok = 1'b0;
    send_range(1, 0, 36, 1'b1);
    wait_sig_ov();
    checks++; if (out_valid !== 1'b1 || px_out !== 8'd18) begin errors++; $display("FAIL timeout_output ov=%0b px=%0d exp 1 18", out_valid, px_out); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%0b exp=1", err); end
    send_range(1, 37, W*H-1, 1'b0);
    wait_out(8);
    checks++; if (err !== 1'b1 || outq.size() != 8) begin errors++; $display("FAIL timeout_sticky err=%0b count=%0d exp 1 8", err, outq.size()); end
    done_ok = 1'b1;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_backpressure();
    test_sof_restart();
    test_overrun();
    test_reset_in_run();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
